ins_fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the byte-addressed, big-endian instruction ROM. It owns the PC, drives the ROM address, and computes the next PC for sequential, branch, jump and register-jump flow. It latches the combinationally returned instruction word into the IF/ID register (IR plus PC+4) consumed by decode. It also handles stall, redirect squash, halt and address-error detection.

---
 rtl/ins_fetch_unit_pkg.sv | 18 +
 rtl/ins_fetch_unit_next_pc_calc.sv | 35 +++
 rtl/ins_fetch_unit.sv | 99 +++++++++
 tb/tb_ins_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ins_fetch_unit_pkg.sv
// Shared encodings for the instruction-fetch stage: redirect selects, NOP word,
// halt opcode default and fetch FSM states.
package ins_fetch_unit_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  localparam logic [31:0] NOP_WORD            = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE_DEFAULT = 6'b111111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ins_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection (sequential or redirect) plus the fetch
// address legality check against the ROM size.
import ins_fetch_unit_pkg::*;

module next_pc_calc #(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  logic [1:0]  pc_src,
  input  logic        redirect,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_target,
  input  logic [31:0] reg_target,
  output logic [31:0] next_pc,
  output logic        illegal
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  always_comb begin
    next_pc = pc + 32'd4;
    if (redirect) begin
      unique case (pc_src)
        PC_BR:   next_pc = pc4 + {branch_offset[29:0], 2'b00};
        PC_J:    next_pc = {pc4[31:28], jump_target, 2'b00};
        PC_JR:   next_pc = reg_target;
        default: next_pc = pc + 32'd4;
      endcase
    end
  end

  assign illegal = (next_pc[1:0] != 2'b00) || (next_pc > LAST_WORD);

endmodule

// File: rtl/ins_fetch_unit.sv
// Fetch stage: owns the PC, drives the ROM address and fills the IF/ID
// register; RUN/HALT FSM handles stall, redirect squash, halt and address errors.
import ins_fetch_unit_pkg::*;

module ins_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_BYTES   = 512,
  parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [31:0] InsAddr,
  input  logic [31:0] InsData,
  input  logic        Stall,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchOffset,
  input  logic [25:0] JumpTarget,
  input  logic [31:0] RegTarget,
  output logic [31:0] IR,
  output logic [31:0] PC4,
  output logic        Valid,
  output logic        Halt,
  output logic        AddrErr
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  logic         illegal;
  logic         redirect;

  assign InsAddr  = pc;
  assign redirect = Valid && (PCSrc != PC_SEQ);

  next_pc_calc #(.MEM_BYTES(MEM_BYTES)) u_next_pc (
    .pc            (pc),
    .pc4           (PC4),
    .pc_src        (PCSrc),
    .redirect      (redirect),
    .branch_offset (BranchOffset),
    .jump_target   (JumpTarget),
    .reg_target    (RegTarget),
    .next_pc       (next_pc),
    .illegal       (illegal)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state   <= ST_RUN;
      pc      <= RESET_PC;
      IR      <= NOP_WORD;
      PC4     <= 32'h0;
      Valid   <= 1'b0;
      Halt    <= 1'b0;
      AddrErr <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (Stall) begin
            state <= ST_RUN;
          end else if (Valid && (IR[31:26] == HALT_OPCODE)) begin
            state <= ST_HALT;
            Halt  <= 1'b1;
            IR    <= NOP_WORD;
            Valid <= 1'b0;
          end else if (redirect) begin
            IR    <= NOP_WORD;
            Valid <= 1'b0;
            if (illegal) begin
              state   <= ST_HALT;
              Halt    <= 1'b1;
              AddrErr <= 1'b1;
            end else begin
              pc <= next_pc;
            end
          end else if (illegal) begin
            // last legal word is still captured, but fetch stops behind it
            IR      <= InsData;
            PC4     <= next_pc;
            Valid   <= 1'b0;
            state   <= ST_HALT;
            Halt    <= 1'b1;
            AddrErr <= 1'b1;
          end else begin
            IR    <= InsData;
            PC4   <= next_pc;
            Valid <= 1'b1;
            pc    <= next_pc;
          end
        end
        ST_HALT: begin
          Valid <= 1'b0;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Self-checking bench for ins_fetch_unit: big-endian ROM model, table-driven
// vectors and hand sequences, expectations queued per edge and compared after it.
import ins_fetch_unit_pkg::*;

module tb_ins_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] InsAddr;
  logic [31:0] InsData;
  logic        Stall = 1'b0;
  logic [1:0]  PCSrc = PC_SEQ;
  logic [31:0] BranchOffset = '0;
  logic [25:0] JumpTarget = '0;
  logic [31:0] RegTarget = '0;
  logic [31:0] IR;
  logic [31:0] PC4;
  logic        Valid;
  logic        Halt;
  logic        AddrErr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] pc4;
    logic        v;
    logic        h;
    logic        e;
  } exp_t;

  typedef struct {
    logic        stall;
    logic [1:0]  src;
    logic [31:0] boff;
    logic [25:0] jt;
    logic [31:0] rt;
    exp_t        x;
  } vec_t;

  exp_t sb[$];
  logic [7:0] rom [0:511];

  ins_fetch_unit #(
    .RESET_PC    (32'h0),
    .MEM_BYTES   (512),
    .HALT_OPCODE (6'b111111)
  ) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .InsAddr      (InsAddr),
    .InsData      (InsData),
    .Stall        (Stall),
    .PCSrc        (PCSrc),
    .BranchOffset (BranchOffset),
    .JumpTarget   (JumpTarget),
    .RegTarget    (RegTarget),
    .IR           (IR),
    .PC4          (PC4),
    .Valid        (Valid),
    .Halt         (Halt),
    .AddrErr      (AddrErr)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    InsData = 32'h0;
    if (InsAddr <= 32'd508)
      InsData = {rom[InsAddr[8:0]], rom[InsAddr[8:0] + 9'd1],
                 rom[InsAddr[8:0] + 9'd2], rom[InsAddr[8:0] + 9'd3]};
  end

  task automatic put_word(input int addr, input logic [31:0] w);
    rom[addr]     = w[31:24];
    rom[addr + 1] = w[23:16];
    rom[addr + 2] = w[15:8];
    rom[addr + 3] = w[7:0];
  endtask

  function automatic exp_t mx(input logic [31:0] addr, input logic [31:0] ir,
                              input logic [31:0] pc4, input logic v,
                              input logic h, input logic e);
    exp_t r;
    r.addr = addr; r.ir = ir; r.pc4 = pc4; r.v = v; r.h = h; r.e = e;
    return r;
  endfunction

  function automatic vec_t mk(input logic stall, input logic [1:0] src,
                              input logic [31:0] boff, input logic [25:0] jt,
                              input logic [31:0] rt, input exp_t x);
    vec_t r;
    r.stall = stall; r.src = src; r.boff = boff; r.jt = jt; r.rt = rt; r.x = x;
    return r;
  endfunction

  task automatic chk(input string name, input string fld,
                     input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", name, fld, act, expv);
    end
  endtask

  task automatic compare_out(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty got %h expected queued entry", name, IR);
      return;
    end
    e = sb.pop_front();
    chk(name, "InsAddr", InsAddr, e.addr);
    chk(name, "IR",      IR,      e.ir);
    chk(name, "PC4",     PC4,     e.pc4);
    chk(name, "Valid",   {31'b0, Valid},   {31'b0, e.v});
    chk(name, "Halt",    {31'b0, Halt},    {31'b0, e.h});
    chk(name, "AddrErr", {31'b0, AddrErr}, {31'b0, e.e});
  endtask

  task automatic step(input string name, input vec_t v);
    Stall = v.stall; PCSrc = v.src; BranchOffset = v.boff;
    JumpTarget = v.jt; RegTarget = v.rt;
    sb.push_back(v.x);
    @(posedge CLK);
    #1;
    compare_out(name);
  endtask

  task automatic seq(input string name, input exp_t x);
    step(name, mk(1'b0, PC_SEQ, 32'h0, 26'h0, 32'h0, x));
  endtask

  // Reset asserted mid-cycle; reset values must appear with no clock edge.
  task automatic do_reset(input string name);
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    sb.push_back(mx(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    compare_out(name);
    Stall = 1'b0; PCSrc = PC_SEQ; BranchOffset = '0; JumpTarget = '0; RegTarget = '0;
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 8'h00;
    put_word(32'h000, 32'h1111_1111);
    put_word(32'h004, 32'h2222_2222);
    put_word(32'h008, 32'h3333_3333);
    put_word(32'h014, 32'h5555_5555);
    put_word(32'h040, 32'h4444_4444);
    put_word(32'h080, 32'h8888_8888);
    put_word(32'h1FC, 32'h1FC1_FC1F);

    // sequential fetch from reset
    do_reset("reset0");
    seq("seq1", mx(32'h4,  32'h1111_1111, 32'h4,  1'b1, 1'b0, 1'b0));
    seq("seq2", mx(32'h8,  32'h2222_2222, 32'h8,  1'b1, 1'b0, 1'b0));
    seq("seq3", mx(32'hC,  32'h3333_3333, 32'hC,  1'b1, 1'b0, 1'b0));

    // branch/jump/stall/jr flow, one row per edge
    tbl[0]  = mk(0, PC_SEQ, 0, 0, 0, mx(32'h4,  32'h1111_1111, 32'h4,  1, 0, 0));
    tbl[1]  = mk(0, PC_SEQ, 0, 0, 0, mx(32'h8,  32'h2222_2222, 32'h8,  1, 0, 0));
    tbl[2]  = mk(0, PC_BR,  3, 0, 0, mx(32'h14, 32'h0,         32'h8,  0, 0, 0));
    tbl[3]  = mk(0, PC_BR,  3, 0, 0, mx(32'h18, 32'h5555_5555, 32'h18, 1, 0, 0));
    tbl[4]  = mk(0, PC_J,   0, 26'h20, 0, mx(32'h80, 32'h0,    32'h18, 0, 0, 0));
    tbl[5]  = mk(0, PC_SEQ, 0, 0, 0, mx(32'h84, 32'h8888_8888, 32'h84, 1, 0, 0));
    tbl[6]  = mk(1, PC_BR, 32'hFFFF_FFEF, 0, 0, mx(32'h84, 32'h8888_8888, 32'h84, 1, 0, 0));
    tbl[7]  = mk(1, PC_BR, 32'hFFFF_FFEF, 0, 0, mx(32'h84, 32'h8888_8888, 32'h84, 1, 0, 0));
    tbl[8]  = mk(0, PC_BR, 32'hFFFF_FFEF, 0, 0, mx(32'h40, 32'h0, 32'h84, 0, 0, 0));
    tbl[9]  = mk(0, PC_SEQ, 0, 0, 0, mx(32'h44, 32'h4444_4444, 32'h44, 1, 0, 0));
    tbl[10] = mk(0, PC_JR,  0, 0, 32'h40, mx(32'h40, 32'h0,    32'h44, 0, 0, 0));
    tbl[11] = mk(0, PC_SEQ, 0, 0, 0, mx(32'h44, 32'h4444_4444, 32'h44, 1, 0, 0));
    tbl[12] = mk(0, PC_JR,  0, 0, 32'h42, mx(32'h44, 32'h0,    32'h44, 0, 1, 1));
    tbl[13] = mk(0, PC_SEQ, 0, 0, 0, mx(32'h44, 32'h0,         32'h44, 0, 1, 1));
    tbl[14] = mk(1, PC_J,   0, 26'h10, 0, mx(32'h44, 32'h0,    32'h44, 0, 1, 1));
    do_reset("reset_tbl");
    for (int i = 0; i < 15; i++) step($sformatf("vec%0d", i), tbl[i]);

    // halt opcode at 8: halts on the edge after it reaches IR
    put_word(32'h008, 32'hFC00_0000);
    do_reset("reset_halt");
    seq("halt_e1", mx(32'h4, 32'h1111_1111, 32'h4, 1, 0, 0));
    seq("halt_e2", mx(32'h8, 32'h2222_2222, 32'h8, 1, 0, 0));
    seq("halt_e3", mx(32'hC, 32'hFC00_0000, 32'hC, 1, 0, 0));
    seq("halt_e4", mx(32'hC, 32'h0,         32'hC, 0, 1, 0));
    step("halt_e5", mk(1, PC_JR, 0, 0, 32'h40, mx(32'hC, 32'h0, 32'hC, 0, 1, 0)));
    put_word(32'h008, 32'h3333_3333);

    // last ROM word then sequential overflow
    do_reset("reset_bnd");
    seq("bnd_e1", mx(32'h4, 32'h1111_1111, 32'h4, 1, 0, 0));
    step("bnd_jr", mk(0, PC_JR, 0, 0, 32'h1FC, mx(32'h1FC, 32'h0, 32'h4, 0, 0, 0)));
    seq("bnd_last", mx(32'h1FC, 32'h1FC1_FC1F, 32'h200, 0, 1, 1));
    seq("bnd_hold", mx(32'h1FC, 32'h1FC1_FC1F, 32'h200, 0, 1, 1));

    // async reset while a jump redirect is pending
    do_reset("reset_async0");
    seq("as_e1", mx(32'h4, 32'h1111_1111, 32'h4, 1, 0, 0));
    seq("as_e2", mx(32'h8, 32'h2222_2222, 32'h8, 1, 0, 0));
    PCSrc = PC_J; JumpTarget = 26'h30;
    do_reset("reset_mid_jump");
    seq("as_after", mx(32'h4, 32'h1111_1111, 32'h4, 1, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
